// File: rtl/activation_capture_lenet.sv
// rtl/activation_capture_lenet.sv - preamble-armed frame capture with per-lane accumulation across repetitions
// Sums every 16-bit lane of each image beat over all repetitions; sums are read back through a registered port.
module activation_capture_lenet #(
   parameter int DATA_WIDTH            = 256,
   parameter int SAMPLE_WIDTH          = 16,
   parameter int PER_IMAGE_CYCLE       = 49,
   parameter int REPETITION_TIMES      = 300,
   parameter int PREAMBLE_CYCLE_LENGTH = 10,
   parameter logic [DATA_WIDTH-1:0] PREAMBLE_WORD = {16{16'h7FFF}},
   localparam int LANES        = DATA_WIDTH / SAMPLE_WIDTH,
   localparam int ACC_WIDTH    = SAMPLE_WIDTH + $clog2(REPETITION_TIMES),
   localparam int ADDR_WIDTH   = $clog2(PER_IMAGE_CYCLE),
   localparam int ROW_WIDTH    = LANES * ACC_WIDTH,
   localparam int PCOUNT_WIDTH = $clog2(PREAMBLE_CYCLE_LENGTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_in_valid,
   input  logic                  data_in_last,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ROW_WIDTH-1:0]  rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           rep_count
);

   typedef enum logic [2:0] {IDLE, HUNT, CAPTURE, DONE, ERROR} state_t;

   localparam logic [ADDR_WIDTH-1:0]   LAST_BEAT = ADDR_WIDTH'(PER_IMAGE_CYCLE - 1);
   localparam logic [15:0]             LAST_REP  = 16'(REPETITION_TIMES - 1);
   localparam logic [PCOUNT_WIDTH-1:0] PRE_FULL  = PCOUNT_WIDTH'(PREAMBLE_CYCLE_LENGTH);

   state_t                  state, state_next;
   logic [PCOUNT_WIDTH-1:0] pcount, pcount_next;
   logic [ADDR_WIDTH-1:0]   beat, beat_next;
   logic [15:0]             rep_next;
   logic                    done_next, error_next;
   logic                    capture_beat;
   logic                    final_beat;
   logic [ROW_WIDTH-1:0]    acc_old;
   logic [ROW_WIDTH-1:0]    acc_new;

   logic [ROW_WIDTH-1:0] acc [PER_IMAGE_CYCLE];

   assign busy       = (state == HUNT) || (state == CAPTURE);
   assign final_beat = (beat == LAST_BEAT) && (rep_count == LAST_REP);
   assign acc_old    = acc[beat];

   // Frame 0 overwrites the row so stale sums from an aborted capture never leak in.
   always_comb begin
      acc_new = '0;
      for (int k = 0; k < LANES; k++) begin
         logic [SAMPLE_WIDTH-1:0] sample;
         logic [ACC_WIDTH-1:0]    ext;
         sample = data_in[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
         ext    = {{(ACC_WIDTH-SAMPLE_WIDTH){sample[SAMPLE_WIDTH-1]}}, sample};
         if (rep_count == 16'd0)
            acc_new[k*ACC_WIDTH +: ACC_WIDTH] = ext;
         else
            acc_new[k*ACC_WIDTH +: ACC_WIDTH] = acc_old[k*ACC_WIDTH +: ACC_WIDTH] + ext;
      end
   end

   always_comb begin
      state_next   = state;
      pcount_next  = pcount;
      beat_next    = beat;
      rep_next     = rep_count;
      done_next    = done;
      error_next   = error;
      capture_beat = 1'b0;

      if (arm) begin
         state_next  = HUNT;
         pcount_next = '0;
         beat_next   = '0;
         rep_next    = '0;
         done_next   = 1'b0;
         error_next  = 1'b0;
      end else if (data_in_valid) begin
         case (state)
            HUNT: begin
               if (data_in == PREAMBLE_WORD) begin
                  if (pcount != PRE_FULL)
                     pcount_next = pcount + 1'b1;
               end else if (pcount == PRE_FULL) begin
                  capture_beat = 1'b1;
               end else begin
                  pcount_next = '0;
               end
            end
            CAPTURE: capture_beat = 1'b1;
            default: ;
         endcase
      end

      // The first non-preamble word after a full preamble is beat 0 of frame 0.
      if (capture_beat) begin
         state_next = CAPTURE;
         if (final_beat) begin
            if (data_in_last) begin
               rep_next   = rep_count + 16'd1;
               state_next = DONE;
               done_next  = 1'b1;
            end else begin
               state_next = ERROR;
               error_next = 1'b1;
            end
         end else if (data_in_last) begin
            state_next = ERROR;
            error_next = 1'b1;
         end else if (beat == LAST_BEAT) begin
            beat_next = '0;
            rep_next  = rep_count + 16'd1;
         end else begin
            beat_next = beat + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pcount    <= '0;
         beat      <= '0;
         rep_count <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_next;
         pcount    <= pcount_next;
         beat      <= beat_next;
         rep_count <= rep_next;
         done      <= done_next;
         error     <= error_next;
      end
   end

   always_ff @(posedge clk) begin
      if (capture_beat && !rst)
         acc[beat] <= acc_new;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rd_data <= '0;
      else if (rd_addr < ADDR_WIDTH'(PER_IMAGE_CYCLE))
         rd_data <= acc[rd_addr];
      else
         rd_data <= '0;
   end

endmodule

// File: tb/tb_activation_capture_lenet.sv
// tb/tb_activation_capture_lenet.sv - directed bench for activation_capture_lenet
// Drives inputs and samples outputs on the falling edge; expected sums are worked out by hand.
module tb_activation_capture_lenet;

   logic         clk = 1'b0;
   logic         rst;
   logic         arm;
   logic [255:0] data_in;
   logic         data_in_valid;
   logic         data_in_last;
   logic [5:0]   rd_addr;
   logic [399:0] rd_data;
   logic         busy;
   logic         done;
   logic         error;
   logic [15:0]  rep_count;

   int errors = 0;
   int checks = 0;

   localparam logic [255:0] PRE = {16{16'h7FFF}};

   always #5 clk = ~clk;

   activation_capture_lenet dut (
      .clk(clk), .rst(rst), .arm(arm),
      .data_in(data_in), .data_in_valid(data_in_valid), .data_in_last(data_in_last),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done(done), .error(error), .rep_count(rep_count)
   );

   function automatic logic [399:0] acc_row(input logic [24:0] v);
      logic [399:0] r;
      for (int k = 0; k < 16; k++) r[k*25 +: 25] = v;
      return r;
   endfunction

   function automatic logic [255:0] lanes(input logic [15:0] v);
      return {16{v}};
   endfunction

   task automatic check(input string tag, input logic [399:0] obs, input logic [399:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [255:0] d, input logic v, input logic l);
      @(negedge clk);
      data_in       = d;
      data_in_valid = v;
      data_in_last  = l;
   endtask

   task automatic idle();
      @(negedge clk);
      data_in_valid = 1'b0;
      data_in_last  = 1'b0;
   endtask

   task automatic arm_pulse();
      @(negedge clk);
      arm           = 1'b1;
      data_in_valid = 1'b0;
      data_in_last  = 1'b0;
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic preamble(input int n);
      repeat (n) step(PRE, 1'b1, 1'b0);
   endtask

   // mode 0: lanes = beat index, 1: lanes = -1, 2: lanes = 7
   task automatic run_frames(input int n, input int mode, input bit set_last, input bit bubbles);
      logic [15:0] v;
      for (int f = 0; f < n; f++) begin
         for (int b = 0; b < 49; b++) begin
            if (bubbles)
               step({8{$urandom()}}, 1'b0, 1'b1);
            v = (mode == 0) ? 16'(b) : (mode == 1) ? 16'hFFFF : 16'd7;
            step(lanes(v), 1'b1, set_last && (f == n - 1) && (b == 48));
         end
      end
   endtask

   task automatic read_check(input string tag, input logic [5:0] a, input logic [399:0] exp);
      @(negedge clk);
      data_in_valid = 1'b0;
      data_in_last  = 1'b0;
      rd_addr       = a;
      @(negedge clk);
      check(tag, rd_data, exp);
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; data_in = '0; data_in_valid = 1'b0; data_in_last = 1'b0; rd_addr = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 400'(busy), 400'(0));
      check("reset_done", 400'(done), 400'(0));
      check("reset_error", 400'(error), 400'(0));
      check("reset_rep", 400'(rep_count), 400'(0));
      check("reset_rd_data", rd_data, 400'(0));
      rst = 1'b0;

      // Short preamble: 9 beats then data must not arm; a broken rearm would misalign framing later.
      arm_pulse();
      check("hunt_busy", 400'(busy), 400'(1));
      preamble(9);
      step(lanes(16'd3), 1'b1, 1'b0);
      step(PRE, 1'b1, 1'b0);
      step(lanes(16'd3), 1'b1, 1'b0);
      idle();
      check("short_pre_busy", 400'(busy), 400'(1));
      check("short_pre_rep", 400'(rep_count), 400'(0));

      // Partial capture of constant 7, then abort with arm.
      preamble(10);
      run_frames(150, 2, 1'b0, 1'b0);
      idle();
      check("abort_rep_before", 400'(rep_count), 400'(150));
      check("abort_busy_before", 400'(busy), 400'(1));
      arm_pulse();
      check("abort_rep_after", 400'(rep_count), 400'(0));
      check("abort_busy_after", 400'(busy), 400'(1));

      // Nominal full capture after the abort.
      preamble(10);
      run_frames(300, 0, 1'b1, 1'b0);
      idle();
      check("nom_done", 400'(done), 400'(1));
      check("nom_busy", 400'(busy), 400'(0));
      check("nom_error", 400'(error), 400'(0));
      check("nom_rep", 400'(rep_count), 400'(300));
      read_check("nom_addr5", 6'd5, acc_row(25'd1500));
      read_check("nom_addr0", 6'd0, acc_row(25'd0));
      read_check("nom_addr48", 6'd48, acc_row(25'd14400));
      read_check("nom_addr49", 6'd49, 400'(0));
      read_check("nom_addr63", 6'd63, 400'(0));
      step(lanes(16'd9), 1'b1, 1'b1);
      step(PRE, 1'b1, 1'b0);
      idle();
      check("done_ignores_rep", 400'(rep_count), 400'(300));
      check("done_sticky", 400'(done), 400'(1));
      read_check("done_ignores_ram", 6'd5, acc_row(25'd1500));

      // Signed lanes with a bubble before every beat.
      arm_pulse();
      check("arm_clears_done", 400'(done), 400'(0));
      preamble(10);
      run_frames(300, 1, 1'b1, 1'b1);
      idle();
      check("neg_done", 400'(done), 400'(1));
      check("neg_rep", 400'(rep_count), 400'(300));
      read_check("neg_addr0", 6'd0, acc_row(25'h1FFFED4));
      read_check("neg_addr30", 6'd30, acc_row(25'h1FFFED4));

      // Early last on beat 20 of frame 3.
      arm_pulse();
      preamble(10);
      run_frames(3, 0, 1'b0, 1'b0);
      for (int b = 0; b < 20; b++) step(lanes(16'(b)), 1'b1, 1'b0);
      step(lanes(16'd20), 1'b1, 1'b1);
      idle();
      check("early_error", 400'(error), 400'(1));
      check("early_done", 400'(done), 400'(0));
      check("early_busy", 400'(busy), 400'(0));
      check("early_rep", 400'(rep_count), 400'(3));
      run_frames(1, 0, 1'b1, 1'b0);
      idle();
      check("error_ignores_rep", 400'(rep_count), 400'(3));
      check("error_sticky", 400'(error), 400'(1));

      // Final beat without last.
      arm_pulse();
      check("arm_clears_error", 400'(error), 400'(0));
      preamble(10);
      run_frames(300, 0, 1'b0, 1'b0);
      idle();
      check("miss_error", 400'(error), 400'(1));
      check("miss_rep", 400'(rep_count), 400'(299));
      check("miss_done", 400'(done), 400'(0));
      check("miss_busy", 400'(busy), 400'(0));

      // Synchronous reset in the middle of a capture.
      arm_pulse();
      preamble(10);
      run_frames(150, 0, 1'b0, 1'b0);
      idle();
      check("rst_rep_before", 400'(rep_count), 400'(150));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 400'(busy), 400'(0));
      check("rst_done", 400'(done), 400'(0));
      check("rst_error", 400'(error), 400'(0));
      check("rst_rep", 400'(rep_count), 400'(0));
      arm_pulse();
      check("rearm_busy", 400'(busy), 400'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/activation_capture_lenet.md
# activation_capture_lenet

Receiver for the first-layer activation stream produced by the image SRAM reader. It sits at the ADC-facing end of the LeNet photonic datapath. It detects the preamble, then captures PER_IMAGE_CYCLE-beat image frames repeated REPETITION_TIMES times, and accumulates each 16-bit sample lane across repetitions into an internal RAM. It also checks frame framing through the `last` flag and exposes the accumulated sums through a registered read port for calibration and readback.

## Interface
Parameters:
- DATA_WIDTH, 256: stream word width.
- SAMPLE_WIDTH, 16: width of one signed lane. LANES = DATA_WIDTH/SAMPLE_WIDTH (16).
- PER_IMAGE_CYCLE, 49: beats per image frame.
- REPETITION_TIMES, 300: frames per image.
- PREAMBLE_CYCLE_LENGTH, 10: consecutive preamble beats required to arm capture.
- PREAMBLE_WORD, {16{16'h7FFF}}: preamble pattern.
- Derived localparams: ACC_WIDTH = SAMPLE_WIDTH + $clog2(REPETITION_TIMES) (25); ADDR_WIDTH = $clog2(PER_IMAGE_CYCLE) (6).

Ports:
- Clock and reset (already decided): reset rst, synchronous, active-high; clock clk.
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- arm, input, 1: single-cycle pulse that starts a preamble hunt.
- data_in, input, DATA_WIDTH: stream data.
- data_in_valid, input, 1: beat qualifier.
- data_in_last, input, 1: end-of-image marker.
- rd_addr, input, ADDR_WIDTH: accumulator read address.
- rd_data, output, LANES*ACC_WIDTH: accumulated sums, lane 0 in the LSBs.
- busy, output, 1: state is HUNT or CAPTURE.
- done, output, 1: capture completed successfully; sticky.
- error, output, 1: framing error; sticky.
- rep_count, output, 16: completed frames in the current capture.

## Operation
States: IDLE, HUNT, CAPTURE, DONE, ERROR.

- **Reset:** state=IDLE. pcount, beat, rep_count, done, error and rd_data are all cleared to 0. Accumulator RAM contents are not cleared.
- **arm:** from any state, arm forces HUNT and clears pcount, beat, rep_count, done and error. arm during CAPTURE aborts the capture. arm has priority over a data beat in the same cycle; that beat is dropped.
- **HUNT:** only valid beats are counted; invalid cycles hold pcount.
  - data_in==PREAMBLE_WORD: pcount increments, saturating at PREAMBLE_CYCLE_LENGTH.
  - Any other word: if pcount==PREAMBLE_CYCLE_LENGTH, this beat is beat 0 of frame 0. It is processed as a CAPTURE beat and the state becomes CAPTURE. Otherwise pcount=0.
  - data_in_last in HUNT is ignored.
- **CAPTURE:** each valid beat at address `beat`:
  - If rep_count==0: acc[beat] = sign-extended lanes.
  - Otherwise: acc[beat] = acc[beat] + sign-extended lanes, per lane, ACC_WIDTH wrap-around. No overflow is possible at the default parameters.
  - beat increments. At beat==PER_IMAGE_CYCLE-1 it wraps to 0 and rep_count increments.
  - Invalid cycles change nothing.
- **Framing checks on a valid CAPTURE beat:**
  - last asserted when the beat is not (beat==PER_IMAGE_CYCLE-1 and rep_count==REPETITION_TIMES-1): go to ERROR.
  - Final beat (beat==PER_IMAGE_CYCLE-1, rep_count==REPETITION_TIMES-1) with last=1: the beat is accumulated, rep_count becomes REPETITION_TIMES, go to DONE.
  - Final beat with last=0: go to ERROR. The beat is still accumulated.
  - A word equal to PREAMBLE_WORD inside CAPTURE is treated as ordinary data.
- **DONE / ERROR:** input beats are ignored. Only arm or rst leaves these states. In ERROR, RAM contents are partial and undefined for readback.
- **Read port:** rd_data <= acc[rd_addr] every cycle in every state. rd_addr ≥ PER_IMAGE_CYCLE returns 0.

## Timing
- One beat per cycle sustained. The read-modify-write is single-cycle (combinational read, write at the clock edge). Consecutive beats never hit the same address because PER_IMAGE_CYCLE > 1.
- State, done, error and rep_count are registered and update at the edge that samples the qualifying beat. done is visible the cycle after the final beat is presented.
- rd_data has 1-cycle latency from rd_addr. A read of the address written at edge N returns the new value if issued from edge N onward.
- busy deasserts at the same edge that done or error asserts.
- rst mid-CAPTURE:
  - IDLE at the next edge.
  - A partially accumulated RAM is left as is; the next capture overwrites it during frame 0.

## Test plan
- **Nominal:** arm; 10 preamble beats; 300 frames of 49 beats, where beat b of every frame has all lanes = b and last is set on the final beat.
  - Expected: done=1 one cycle later; rep_count=300; rd_data lane k at addr 5 = 1500.
- **Signed/bubbles:** lanes = 16'hFFFF (−1) with valid toggling every other cycle.
  - Expected: each acc lane = −300 (25'h1FFFED4); capture time doubles; result is identical.
- **Short preamble:** 9 preamble beats, then data.
  - Expected: stays in HUNT, pcount resets to 0, no RAM write. A later 10-beat preamble arms correctly.
- **Early last:** last asserted on beat 20 of frame 3.
  - Expected: error=1, done=0, busy=0; subsequent beats ignored.
- **Missing last:** final beat without last.
  - Expected: error=1, rep_count=299.
- **Abort/reset:**
  - arm pulsed at frame 150: state returns to HUNT, rep_count=0; a following full capture gives correct sums with no stale accumulation.
  - rst at frame 150: state returns to IDLE; done, error and rep_count read 0.
